// File: rtl/controller_scratchpad_launcher_if.sv
// OBI register-port bundle between the launcher and the controller_scratchpad
// register block. The launcher drives the request half via 'master' and
// receives the response half via 'slave'.
interface controller_scratchpad_launcher_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  // Request half, driven by the initiator
  modport master (
    output req, addr, we, be, wdata
  );

  // Response half, observed by the initiator
  modport slave (
    input gnt, rvalid, rdata
  );
endinterface

// File: rtl/controller_scratchpad_launcher.sv
// Host-side OBI initiator that runs the core launch sequence on the
// controller_scratchpad register port: enable the clock, hold and then release
// the core reset, poll STATUS until done (or a poll budget runs out), then
// gate the clock with the reset held again.
module controller_scratchpad_launcher #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter logic [31:0] CTRL_OFFSET   = 32'h0,
  parameter logic [31:0] STATUS_OFFSET = 32'h4,
  parameter logic [31:0] DONE_MASK     = 32'h1,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned POLL_MAX      = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  controller_scratchpad_launcher_if.master regs_req,
  controller_scratchpad_launcher_if.slave  regs_rsp,
  input  logic                            start_i,
  input  logic                            abort_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            timeout_o,
  output logic [15:0]                     poll_cnt_o
);

  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFFSET;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFFSET;
  localparam logic [31:0] RST_LAST    = RST_CYCLES - 1;
  // Poll budget clamped to what the 16-bit saturating counter can reach
  localparam logic [15:0] POLL_LIM    = (POLL_MAX > 32'd65535) ? 16'hFFFF : POLL_MAX[15:0];

  localparam logic [31:0] CTRL_CLKON = 32'h1;
  localparam logic [31:0] CTRL_RUN   = 32'h3;
  localparam logic [31:0] CTRL_STOP  = 32'h0;

  typedef enum logic [3:0] {
    IDLE,
    CLKON_REQ,
    CLKON_RSP,
    RST_WAIT,
    RUN_REQ,
    RUN_RSP,
    POLL_REQ,
    POLL_RSP,
    STOP_REQ,
    STOP_RSP
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] rst_cnt;
  logic [15:0] poll_cnt;
  logic        timeout;
  logic        abort_pend;

  logic        start_acc;
  logic        poll_inc;
  logic        set_timeout;
  logic        abort_now;
  logic        done_bit;
  logic        in_abortable;

  // A request is never withdrawn once raised, so an abort seen in a REQ/RSP
  // state is remembered here and acted on when that transaction's response
  // arrives, even if abort_i has already dropped by then.
  assign in_abortable = (state == CLKON_REQ) || (state == CLKON_RSP) ||
                        (state == RUN_REQ)   || (state == RUN_RSP)   ||
                        (state == POLL_REQ)  || (state == POLL_RSP);
  assign abort_now    = abort_i || abort_pend;
  assign done_bit     = |(regs_rsp.rdata & DONE_MASK);

  // State register and run bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      poll_cnt   <= '0;
      timeout    <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == RST_WAIT) rst_cnt <= rst_cnt + 32'd1;
      else                   rst_cnt <= '0;

      if (start_acc)                         poll_cnt <= '0;
      else if (poll_inc && poll_cnt != '1)   poll_cnt <= poll_cnt + 16'd1;

      if (start_acc)        timeout <= 1'b0;
      else if (set_timeout) timeout <= 1'b1;

      if (state == IDLE || state == STOP_REQ) abort_pend <= 1'b0;
      else if (abort_i && in_abortable)       abort_pend <= 1'b1;
    end
  end

  // Next-state and OBI request generation
  always_comb begin
    state_nxt      = state;
    start_acc      = 1'b0;
    poll_inc       = 1'b0;
    set_timeout    = 1'b0;
    done_o         = 1'b0;
    regs_req.req   = 1'b0;
    regs_req.addr  = '0;
    regs_req.we    = 1'b0;
    regs_req.be    = '0;
    regs_req.wdata = '0;

    unique case (state)
      IDLE: begin
        if (start_i && !abort_i) begin
          start_acc = 1'b1;
          state_nxt = CLKON_REQ;
        end
      end

      CLKON_REQ: begin
        regs_req.req   = 1'b1;
        regs_req.addr  = CTRL_ADDR;
        regs_req.we    = 1'b1;
        regs_req.be    = '1;
        regs_req.wdata = CTRL_CLKON;
        if (regs_rsp.gnt) state_nxt = CLKON_RSP;
      end

      CLKON_RSP: begin
        if (regs_rsp.rvalid) state_nxt = abort_now ? STOP_REQ : RST_WAIT;
      end

      RST_WAIT: begin
        if (abort_now)                state_nxt = STOP_REQ;
        else if (rst_cnt == RST_LAST) state_nxt = RUN_REQ;
      end

      RUN_REQ: begin
        regs_req.req   = 1'b1;
        regs_req.addr  = CTRL_ADDR;
        regs_req.we    = 1'b1;
        regs_req.be    = '1;
        regs_req.wdata = CTRL_RUN;
        if (regs_rsp.gnt) state_nxt = RUN_RSP;
      end

      RUN_RSP: begin
        if (regs_rsp.rvalid) state_nxt = abort_now ? STOP_REQ : POLL_REQ;
      end

      POLL_REQ: begin
        regs_req.req  = 1'b1;
        regs_req.addr = STATUS_ADDR;
        regs_req.be   = '1;
        if (regs_rsp.gnt) begin
          poll_inc  = 1'b1;
          state_nxt = POLL_RSP;
        end
      end

      POLL_RSP: begin
        // Abort or done both end the run cleanly; the timeout flag is only
        // raised when neither applies and the poll budget is spent.
        if (regs_rsp.rvalid) begin
          if (abort_now || done_bit) begin
            state_nxt = STOP_REQ;
          end else if (poll_cnt == POLL_LIM) begin
            set_timeout = 1'b1;
            state_nxt   = STOP_REQ;
          end else begin
            state_nxt = POLL_REQ;
          end
        end
      end

      STOP_REQ: begin
        regs_req.req   = 1'b1;
        regs_req.addr  = CTRL_ADDR;
        regs_req.we    = 1'b1;
        regs_req.be    = '1;
        regs_req.wdata = CTRL_STOP;
        if (regs_rsp.gnt) state_nxt = STOP_RSP;
      end

      STOP_RSP: begin
        if (regs_rsp.rvalid) begin
          done_o    = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o     = (state != IDLE);
  assign timeout_o  = timeout;
  assign poll_cnt_o = poll_cnt;

endmodule

// File: tb/tb_controller_scratchpad_launcher.sv
// Directed bench for controller_scratchpad_launcher: a behavioural OBI
// responder with programmable grant/response latency logs every granted
// transaction and flags protocol violations; the main sequence drives launch,
// timeout, abort, ignored-start and mid-transaction reset scenarios.
module tb_controller_scratchpad_launcher;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] CTRL_A = BASE;
  localparam logic [31:0] STAT_A = BASE + 32'h4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, timeout;
  logic [15:0] poll_cnt;

  int checks = 0;
  int failures = 0;

  controller_scratchpad_launcher_if bus ();

  controller_scratchpad_launcher #(
    .BASE_ADDR    (BASE),
    .CTRL_OFFSET  (32'h0),
    .STATUS_OFFSET(32'h4),
    .DONE_MASK    (32'h1),
    .RST_CYCLES   (4),
    .POLL_MAX     (8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .regs_req  (bus),
    .regs_rsp  (bus),
    .start_i   (start),
    .abort_i   (abort),
    .busy_o    (busy),
    .done_o    (done),
    .timeout_o (timeout),
    .poll_cnt_o(poll_cnt)
  );

  always #5 clk = ~clk;

  // Responder configuration and transaction log
  bit          rnd_mode = 1'b0;
  int          g_fix = 0;
  int          r_fix = 1;
  int          done_after = 0;
  int          rd_idx = 0;
  bit          armed = 1'b0;
  int          g_wait = 0;
  bit          rv_pend = 1'b0;
  int          rv_wait = 0;
  logic [31:0] rv_data = '0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic        lg_we[$];
  logic [31:0] lg_addr[$];
  logic [31:0] lg_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural OBI responder, acting between clock edges
  always @(negedge clk) begin
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    if (!rst_n) begin
      armed   = 1'b0;
      rv_pend = 1'b0;
    end else if (rv_pend) begin
      check("one_outstanding", bus.req, 1'b0);
      rv_wait--;
      if (rv_wait == 0) begin
        bus.rvalid = 1'b1;
        bus.rdata  = rv_data;
        rv_pend    = 1'b0;
      end
    end else if (bus.req) begin
      if (!armed) begin
        armed     = 1'b1;
        cap_addr  = bus.addr;
        cap_we    = bus.we;
        cap_wdata = bus.wdata;
        g_wait    = rnd_mode ? int'($urandom_range(0, 5)) : g_fix;
      end else begin
        check("stable_addr", bus.addr, cap_addr);
        check("stable_we", bus.we, cap_we);
        check("stable_wdata", bus.wdata, cap_wdata);
      end
      if (g_wait == 0) begin
        bus.gnt = 1'b1;
        armed   = 1'b0;
        check("be_full", bus.be, 4'hF);
        lg_we.push_back(bus.we);
        lg_addr.push_back(bus.addr);
        lg_data.push_back(bus.wdata);
        if (!bus.we) begin
          rd_idx++;
          rv_data = (done_after != 0 && rd_idx == done_after) ? 32'h0000_0001 : 32'hFFFF_FFFE;
        end else begin
          rv_data = 32'hFFFF_FFFF;
        end
        rv_pend = 1'b1;
        rv_wait = rnd_mode ? int'($urandom_range(1, 4)) : r_fix;
      end else begin
        g_wait--;
      end
    end else if (armed) begin
      check("req_held_until_gnt", bus.req, 1'b1);
      armed = 1'b0;
    end
  end

  task automatic clear_log();
    lg_we.delete();
    lg_addr.delete();
    lg_data.delete();
    rd_idx = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_idle(output int dones, output int busy_cyc);
    dones    = 0;
    busy_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) dones++;
      if (!busy) return;
      busy_cyc++;
      @(negedge clk); #1;
    end
    check("run_bound", busy, 1'b0);
  endtask

  task automatic check_txns(input string tag, input int exp_wr,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input int exp_rd);
    logic [31:0] ew[3];
    int nw = 0;
    int nr = 0;
    ew[0] = e0;
    ew[1] = e1;
    ew[2] = e2;
    for (int i = 0; i < lg_we.size(); i++) begin
      if (lg_we[i]) begin
        if (nw < 3) check({tag, "_wdata"}, lg_data[i], ew[nw]);
        check({tag, "_waddr"}, lg_addr[i], CTRL_A);
        nw++;
      end else begin
        check({tag, "_raddr"}, lg_addr[i], STAT_A);
        check({tag, "_rd_after_run"}, nw, 2);
        nr++;
      end
    end
    check({tag, "_nwr"}, nw, exp_wr);
    check({tag, "_nrd"}, nr, exp_rd);
  endtask

  int d, b;

  initial begin
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", bus.req, 1'b0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_we", bus.we, 1'b0);
    check("rst_be", bus.be, 4'h0);
    check("rst_wdata", bus.wdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_poll_cnt", poll_cnt, 16'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Zero-wait launch, STATUS done on third read
    clear_log();
    done_after = 3;
    pulse_start();
    run_to_idle(d, b);
    check_txns("t1", 3, 32'h1, 32'h3, 32'h0, 3);
    check("t1_poll_cnt", poll_cnt, 16'd3);
    check("t1_done_pulses", d, 1);
    check("t1_timeout", timeout, 1'b0);
    check("t1_cycles", b, 16);

    // Random grant and response latency
    clear_log();
    done_after = 2;
    rnd_mode   = 1'b1;
    pulse_start();
    run_to_idle(d, b);
    rnd_mode = 1'b0;
    check_txns("t2", 3, 32'h1, 32'h3, 32'h0, 2);
    check("t2_done_pulses", d, 1);
    check("t2_poll_cnt", poll_cnt, 16'd2);

    // STATUS never done: poll budget of 8 then timeout
    clear_log();
    done_after = 0;
    pulse_start();
    run_to_idle(d, b);
    check_txns("t3", 3, 32'h1, 32'h3, 32'h0, 8);
    check("t3_timeout", timeout, 1'b1);
    check("t3_done_pulses", d, 1);
    check("t3_poll_cnt", poll_cnt, 16'd8);
    check("t3_cycles", b, 26);

    // Next accepted start clears the sticky timeout
    clear_log();
    done_after = 1;
    pulse_start();
    check("t3b_timeout_clr", timeout, 1'b0);
    check("t3b_busy", busy, 1'b1);
    run_to_idle(d, b);
    check_txns("t3b", 3, 32'h1, 32'h3, 32'h0, 1);
    check("t3b_poll_cnt", poll_cnt, 16'd1);

    // Abort during RST_WAIT: next request is CTRL=0
    clear_log();
    done_after = 0;
    pulse_start();
    @(negedge clk); #1;
    @(negedge clk); #1;
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    check("t4a_req", bus.req, 1'b1);
    check("t4a_we", bus.we, 1'b1);
    check("t4a_addr", bus.addr, CTRL_A);
    check("t4a_wdata", bus.wdata, 32'h0);
    run_to_idle(d, b);
    check_txns("t4a", 2, 32'h1, 32'h0, 32'h0, 0);
    check("t4a_done_pulses", d, 1);
    check("t4a_poll_cnt", poll_cnt, 16'd0);

    // Short abort pulse in POLL_RSP: read completes, then CTRL=0
    clear_log();
    done_after = 0;
    r_fix      = 3;
    pulse_start();
    for (int i = 0; i < 200 && rd_idx == 0; i++) begin
      @(negedge clk); #1;
    end
    check("t4b_read_seen", rd_idx, 1);
    @(negedge clk); #1;
    check("t4b_in_rsp_req", bus.req, 1'b0);
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    run_to_idle(d, b);
    r_fix = 1;
    check_txns("t4b", 3, 32'h1, 32'h3, 32'h0, 1);
    check("t4b_poll_cnt", poll_cnt, 16'd1);
    check("t4b_timeout", timeout, 1'b0);
    check("t4b_done_pulses", d, 1);

    // start while busy is ignored
    clear_log();
    done_after = 2;
    pulse_start();
    repeat (3) begin
      @(negedge clk); #1;
    end
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    run_to_idle(d, b);
    check_txns("t5", 3, 32'h1, 32'h3, 32'h0, 2);
    check("t5_done_pulses", d, 1);

    // start together with abort in IDLE is blocked
    clear_log();
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t5_idle_busy", busy, 1'b0);
      check("t5_idle_req", bus.req, 1'b0);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk); #1;
    check("t5_idle_no_txn", lg_we.size(), 0);
    check("t5_idle_stays", busy, 1'b0);

    // Asynchronous reset while a request waits for grant
    clear_log();
    done_after = 2;
    g_fix      = 10;
    pulse_start();
    @(negedge clk); #1;
    check("t6_req_waiting", bus.req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req_async", bus.req, 1'b0);
    check("t6_busy_async", busy, 1'b0);
    check("t6_addr_async", bus.addr, 32'h0);
    check("t6_poll_cnt_async", poll_cnt, 16'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    g_fix = 0;
    clear_log();
    @(negedge clk); #1;
    check("t6_idle_busy", busy, 1'b0);
    check("t6_idle_req", bus.req, 1'b0);
    pulse_start();
    run_to_idle(d, b);
    check_txns("t6", 3, 32'h1, 32'h3, 32'h0, 2);
    check("t6_done_pulses", d, 1);
    check("t6_poll_cnt", poll_cnt, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
